// File: rtl/comparator_pkg.sv
// Shared types and result codes for the serial magnitude comparator.
// One-hot result encodings and the controller state type.
package comparator_pkg;

   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;
   localparam logic [2:0] RES_NONE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Map a digit verdict onto the one-hot result code.
   function automatic logic [2:0] res_encode(
      input logic gt,
      input logic lt
   );
      logic [2:0] r;
      unique case (1'b1)
         gt:      r = RES_GT;
         lt:      r = RES_LT;
         default: r = RES_EQ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational compare of one DIGIT-bit slice.
// Exactly one of gt/eq/lt is high.
module comparator_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   // Unsigned magnitude relation of the two slices.
   always_comb begin
      gt = (a > b);
      eq = (a == b);
      lt = (a < b);
   end

endmodule

// File: rtl/comparator_serial.sv
// MSB-first serial comparator, one digit per cycle.
// Stops at the first differing digit; abort cancels a run.
module comparator_serial
   import comparator_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          signed_mode,
   input  logic [WIDTH-1:0]              a,
   input  logic [WIDTH-1:0]              b,
   output logic                          busy,
   output logic                          done,
   output logic [2:0]                    y,
   output logic [$clog2(WIDTH/DIGIT):0]  cycles
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [CW-1:0]    idx;
   logic             dig_gt;
   logic             dig_eq;
   logic             dig_lt;
   logic             accept;
   logic             decide;
   logic             in_run;

   comparator_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .a  (op_a[WIDTH-1 -: DIGIT]),
      .b  (op_b[WIDTH-1 -: DIGIT]),
      .gt (dig_gt),
      .eq (dig_eq),
      .lt (dig_lt)
   );

   assign in_run = (state == ST_RUN);
   // Abort blocks both a new start and a pending verdict.
   assign accept = !in_run && start && !abort;
   assign decide = in_run && !abort &&
                   (!dig_eq || idx == LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (accept) state_nx = ST_RUN;
         ST_RUN: begin
            if (abort)       state_nx = ST_IDLE;
            else if (decide) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_DONE);
   end

   // Operand capture, digit shift and result latch.
   // Signed compare: flipping both MSBs turns it unsigned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         idx    <= '0;
         y      <= RES_NONE;
         cycles <= '0;
      end else if (accept) begin
         op_a <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
         op_b <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
         idx  <= '0;
      end else if (decide) begin
         y      <= res_encode(dig_gt, dig_lt);
         cycles <= idx + CW'(1);
      end else if (in_run && !abort) begin
         op_a <= op_a << DIGIT;
         op_b <= op_b << DIGIT;
         idx  <= idx + CW'(1);
      end
   end

endmodule
